// File: rtl/frame_buf_sched_if.sv
// frame_buf_sched_if: handshake and address bundle between the slot scheduler and the DDR controllers.
// Latency: none, wires only.
// Backpressure: carries the 4-phase done/ack pairs; the master drives requests, the slave drives acks.
interface frame_buf_sched_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  wr_done_i;
  logic                  wr_done_ack_o;
  logic                  rd_req_i;
  logic                  rd_req_ack_o;
  logic [ADDR_WIDTH-1:0] wr_frame_addr_o;
  logic [ADDR_WIDTH-1:0] rd_frame_addr_o;
  logic                  rd_repeat_o;
  logic [15:0]           drop_cnt_o;
  logic [15:0]           repeat_cnt_o;

  // Controller side: raises requests, watches acks and slot addresses.
  modport master (
    output wr_done_i, rd_req_i,
    input  wr_done_ack_o, rd_req_ack_o, wr_frame_addr_o, rd_frame_addr_o,
    input  rd_repeat_o, drop_cnt_o, repeat_cnt_o
  );

  // Scheduler side.
  modport slave (
    input  wr_done_i, rd_req_i,
    output wr_done_ack_o, rd_req_ack_o, wr_frame_addr_o, rd_frame_addr_o,
    output rd_repeat_o, drop_cnt_o, repeat_cnt_o
  );
endinterface

// File: rtl/frame_buf_sched.sv
// frame_buf_sched: hands DDR frame slots to writer and reader; drops oldest ready frame or repeats on rate mismatch.
// Latency: request edge -> ack and new slot addresses 1 cycle later; a read colliding with a write acks 1 cycle after it.
// Backpressure: 4-phase done/ack per side; ack holds until the request is seen low, new edges during ack are ignored.
// Optional FRAME_SCHED_STATS_EN builds saturating 16-bit drop/repeat counters; otherwise they read as 0.
module frame_buf_sched #(
  parameter int unsigned           ADDR_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR    = '0,
  parameter int unsigned           FRAMES_AMOUNT = 3,
  parameter logic [ADDR_WIDTH-1:0] FRAME_BYTES   = ADDR_WIDTH'(2073600 * 8)
) (
  input logic               clk_i,
  input logic               rst_i,
  frame_buf_sched_if.slave  bus
);

  localparam int unsigned   IW   = $clog2(FRAMES_AMOUNT);
  localparam logic [IW-1:0] LAST = IW'(FRAMES_AMOUNT - 1);

  typedef enum logic {ST_IDLE, ST_ACK} ack_st_e;

  function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
    return (i == LAST) ? '0 : i + IW'(1);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] slot_addr(input logic [IW-1:0] i);
    return START_ADDR + ADDR_WIDTH'(i) * FRAME_BYTES;
  endfunction

  ack_st_e               wr_st_q, wr_st_d, rd_st_q, rd_st_d;
  logic                  wr_done_d1_q, wr_done_d1_d, rd_req_d1_q, rd_req_d1_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [IW-1:0]         wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, rdy_idx_q, rdy_idx_d;
  logic                  rdy_vld_q, rdy_vld_d;
  logic                  rd_repeat_q, rd_repeat_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic                  wr_edge, rd_edge, wr_evt, rd_evt;

  // Edge detection, write-first arbitration and both ack FSMs' next state.
  always_comb begin
    wr_st_d      = wr_st_q;
    rd_st_d      = rd_st_q;
    rd_pend_d    = rd_pend_q;
    wr_evt       = 1'b0;
    rd_evt       = 1'b0;
    wr_done_d1_d = bus.wr_done_i;
    rd_req_d1_d  = bus.rd_req_i;
    wr_edge      = bus.wr_done_i & ~wr_done_d1_q;
    rd_edge      = bus.rd_req_i & ~rd_req_d1_q;
    case (wr_st_q)
      ST_IDLE: if (wr_edge) begin
        wr_evt  = 1'b1;
        wr_st_d = ST_ACK;
      end
      ST_ACK:  if (!bus.wr_done_i) wr_st_d = ST_IDLE;
    endcase
    case (rd_st_q)
      // A read colliding with a write waits one cycle so it sees the frame just completed.
      ST_IDLE: if (rd_edge || rd_pend_q) begin
        if (wr_evt) begin
          rd_pend_d = 1'b1;
        end else begin
          rd_evt    = 1'b1;
          rd_pend_d = 1'b0;
          rd_st_d   = ST_ACK;
        end
      end
      ST_ACK:  if (!bus.rd_req_i) rd_st_d = ST_IDLE;
    endcase
  end

  // Slot ownership update and registered slot addresses.
  always_comb begin
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    rdy_idx_d   = rdy_idx_q;
    rdy_vld_d   = rdy_vld_q;
    rd_repeat_d = rd_repeat_q;
    if (wr_evt) begin
      // Completed slot becomes ready (any older ready frame is dropped); writer moves past the reader.
      rdy_idx_d = wr_idx_q;
      rdy_vld_d = 1'b1;
      wr_idx_d  = (idx_inc(wr_idx_q) == rd_idx_q) ? idx_inc(idx_inc(wr_idx_q)) : idx_inc(wr_idx_q);
    end else if (rd_evt) begin
      if (rdy_vld_q) begin
        rd_idx_d    = rdy_idx_q;
        rdy_vld_d   = 1'b0;
        rd_repeat_d = 1'b0;
      end else begin
        rd_repeat_d = 1'b1;
      end
    end
    wr_addr_d = slot_addr(wr_idx_d);
    rd_addr_d = slot_addr(rd_idx_d);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_st_q      <= ST_IDLE;
      rd_st_q      <= ST_IDLE;
      wr_done_d1_q <= 1'b0;
      rd_req_d1_q  <= 1'b0;
      rd_pend_q    <= 1'b0;
      wr_idx_q     <= '0;
      rd_idx_q     <= LAST;
      rdy_idx_q    <= '0;
      rdy_vld_q    <= 1'b0;
      rd_repeat_q  <= 1'b0;
      wr_addr_q    <= START_ADDR;
      rd_addr_q    <= slot_addr(LAST);
    end else begin
      wr_st_q      <= wr_st_d;
      rd_st_q      <= rd_st_d;
      wr_done_d1_q <= wr_done_d1_d;
      rd_req_d1_q  <= rd_req_d1_d;
      rd_pend_q    <= rd_pend_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      rdy_idx_q    <= rdy_idx_d;
      rdy_vld_q    <= rdy_vld_d;
      rd_repeat_q  <= rd_repeat_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
    end
  end

  assign bus.wr_done_ack_o   = (wr_st_q == ST_ACK);
  assign bus.rd_req_ack_o    = (rd_st_q == ST_ACK);
  assign bus.wr_frame_addr_o = wr_addr_q;
  assign bus.rd_frame_addr_o = rd_addr_q;
  assign bus.rd_repeat_o     = rd_repeat_q;

`ifdef FRAME_SCHED_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d, repeat_cnt_q, repeat_cnt_d;

  // Saturating drop/repeat counters.
  always_comb begin
    drop_cnt_d   = drop_cnt_q;
    repeat_cnt_d = repeat_cnt_q;
    if (wr_evt && rdy_vld_q && (drop_cnt_q != 16'hFFFF))    drop_cnt_d   = drop_cnt_q + 16'd1;
    if (rd_evt && !rdy_vld_q && (repeat_cnt_q != 16'hFFFF)) repeat_cnt_d = repeat_cnt_q + 16'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_q   <= '0;
      repeat_cnt_q <= '0;
    end else begin
      drop_cnt_q   <= drop_cnt_d;
      repeat_cnt_q <= repeat_cnt_d;
    end
  end

  assign bus.drop_cnt_o   = drop_cnt_q;
  assign bus.repeat_cnt_o = repeat_cnt_q;
`else
  assign bus.drop_cnt_o   = '0;
  assign bus.repeat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_frame_buf_sched.sv
// tb_frame_buf_sched: directed and random handshakes on a 3-slot and a 5-slot scheduler.
// Latency: checks acks one cycle after each request edge and one cycle after release.
// Backpressure: requests are held a random number of cycles while ack is high.
module tb_frame_buf_sched;

`ifdef FRAME_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_done = 1'b0;
  logic rd_req = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  frame_buf_sched_if #(.ADDR_WIDTH(32)) if0 ();
  frame_buf_sched_if #(.ADDR_WIDTH(32)) if1 ();

  assign if0.wr_done_i = wr_done;
  assign if0.rd_req_i  = rd_req;
  assign if1.wr_done_i = wr_done;
  assign if1.rd_req_i  = rd_req;

  frame_buf_sched #(.ADDR_WIDTH(32), .START_ADDR(32'd0), .FRAMES_AMOUNT(3), .FRAME_BYTES(32'd1000))
    dut0 (.clk_i(clk), .rst_i(rst), .bus(if0));
  frame_buf_sched #(.ADDR_WIDTH(32), .START_ADDR(32'h100), .FRAMES_AMOUNT(5), .FRAME_BYTES(32'd4096))
    dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));

  // Reference model: who owns which slot, per instance.
  int      m_n[2]  = '{3, 5};
  longint  m_sa[2] = '{0, 256};
  longint  m_fb[2] = '{1000, 4096};
  int      m_wr[2], m_rd[2], m_rdy[2], m_vld[2], m_rep[2], m_drop[2], m_repcnt[2];

  function automatic void m_reset(int k);
    m_wr[k] = 0; m_rd[k] = m_n[k] - 1; m_rdy[k] = 0; m_vld[k] = 0;
    m_rep[k] = 0; m_drop[k] = 0; m_repcnt[k] = 0;
  endfunction

  function automatic void m_write(int k);
    if (m_vld[k] != 0) m_drop[k]++;
    m_rdy[k] = m_wr[k];
    m_vld[k] = 1;
    for (int s = 1; s < m_n[k]; s++) begin
      int c;
      c = (m_rdy[k] + s) % m_n[k];
      if (c != m_rd[k]) begin
        m_wr[k] = c;
        break;
      end
    end
  endfunction

  function automatic void m_read(int k);
    if (m_vld[k] != 0) begin
      m_rd[k] = m_rdy[k]; m_vld[k] = 0; m_rep[k] = 0;
    end else begin
      m_rep[k] = 1; m_repcnt[k]++;
    end
  endfunction

  function automatic logic [63:0] ea(int k, int idx);
    return 64'(m_sa[k] + longint'(idx) * m_fb[k]);
  endfunction

  function automatic logic [63:0] ecnt(int v);
    return STATS ? 64'(v) : 64'd0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":wr_addr0"}, 64'(if0.wr_frame_addr_o), ea(0, m_wr[0]));
    chk({tag, ":rd_addr0"}, 64'(if0.rd_frame_addr_o), ea(0, m_rd[0]));
    chk({tag, ":rep0"},     64'(if0.rd_repeat_o),     64'(m_rep[0]));
    chk({tag, ":drop0"},    64'(if0.drop_cnt_o),      ecnt(m_drop[0]));
    chk({tag, ":repcnt0"},  64'(if0.repeat_cnt_o),    ecnt(m_repcnt[0]));
    chk({tag, ":wr_addr1"}, 64'(if1.wr_frame_addr_o), ea(1, m_wr[1]));
    chk({tag, ":rd_addr1"}, 64'(if1.rd_frame_addr_o), ea(1, m_rd[1]));
    chk({tag, ":rep1"},     64'(if1.rd_repeat_o),     64'(m_rep[1]));
    chk({tag, ":drop1"},    64'(if1.drop_cnt_o),      ecnt(m_drop[1]));
    chk({tag, ":repcnt1"},  64'(if1.repeat_cnt_o),    ecnt(m_repcnt[1]));
  endtask

  // Acks as {wr0, wr1, rd0, rd1}.
  task automatic chk_acks(input string tag, input logic [3:0] exp);
    chk({tag, ":acks"}, 64'({if0.wr_done_ack_o, if1.wr_done_ack_o, if0.rd_req_ack_o, if1.rd_req_ack_o}), 64'(exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr_done = 1'b0; rd_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_reset(0); m_reset(1);
    chk_acks("reset", 4'b0000);
    check_all("reset");
  endtask

  task automatic do_write();
    @(negedge clk);
    wr_done = 1'b1;
    @(negedge clk);
    m_write(0); m_write(1);
    chk_acks("wr_rise", 4'b1100);
    check_all("write");
    repeat ($urandom_range(0, 2)) @(negedge clk);
    chk_acks("wr_hold", 4'b1100);
    wr_done = 1'b0;
    @(negedge clk);
    chk_acks("wr_fall", 4'b0000);
  endtask

  task automatic do_read();
    @(negedge clk);
    rd_req = 1'b1;
    @(negedge clk);
    m_read(0); m_read(1);
    chk_acks("rd_rise", 4'b0011);
    check_all("read");
    repeat ($urandom_range(0, 2)) @(negedge clk);
    chk_acks("rd_hold", 4'b0011);
    rd_req = 1'b0;
    @(negedge clk);
    chk_acks("rd_fall", 4'b0000);
  endtask

  task automatic do_both();
    @(negedge clk);
    wr_done = 1'b1; rd_req = 1'b1;
    @(negedge clk);
    m_write(0); m_write(1);
    chk_acks("both_wr", 4'b1100);
    check_all("both_wr");
    @(negedge clk);
    m_read(0); m_read(1);
    chk_acks("both_rd", 4'b1111);
    check_all("both_rd");
    wr_done = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    chk_acks("both_fall", 4'b0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset(0); m_reset(1);
    // Reset state.
    do_reset();
    chk("t1_wr_addr", 64'(if0.wr_frame_addr_o), 64'd0);
    chk("t1_rd_addr", 64'(if0.rd_frame_addr_o), 64'd2000);

    // Read with nothing completed repeats the reset slot.
    do_read();
    chk("t3_rd_addr", 64'(if0.rd_frame_addr_o), 64'd2000);
    chk("t3_repeat", 64'(if0.rd_repeat_o), 64'd1);

    // Write then read.
    do_reset();
    do_write();
    chk("t2_wr_addr", 64'(if0.wr_frame_addr_o), 64'd1000);
    do_read();
    chk("t2_rd_addr", 64'(if0.rd_frame_addr_o), 64'd0);
    chk("t2_repeat", 64'(if0.rd_repeat_o), 64'd0);

    // Writer outruns reader: three writes, oldest frames dropped.
    do_reset();
    do_write();
    chk("t4_wr_addr_a", 64'(if0.wr_frame_addr_o), 64'd1000);
    do_write();
    chk("t4_wr_addr_b", 64'(if0.wr_frame_addr_o), 64'd0);
    do_write();
    chk("t4_wr_addr_c", 64'(if0.wr_frame_addr_o), 64'd1000);
    chk("t4_drop", 64'(if0.drop_cnt_o), STATS ? 64'd2 : 64'd0);

    // Simultaneous write and read after one prior write.
    do_reset();
    do_write();
    do_both();
    chk("t5_rd_addr", 64'(if0.rd_frame_addr_o), 64'd1000);

    // Reset in the middle of a write handshake, request held through reset.
    do_reset();
    @(negedge clk);
    wr_done = 1'b1;
    @(negedge clk);
    m_write(0); m_write(1);
    chk_acks("t6_pre", 4'b1100);
    rst = 1'b1;
    @(negedge clk);
    m_reset(0); m_reset(1);
    chk_acks("t6_in_rst", 4'b0000);
    check_all("t6_in_rst");
    rst = 1'b0;
    @(negedge clk);
    m_write(0); m_write(1);
    chk_acks("t6_reserve", 4'b1100);
    check_all("t6_reserve");
    repeat (2) @(negedge clk);
    check_all("t6_once");
    wr_done = 1'b0;
    @(negedge clk);
    chk_acks("t6_fall", 4'b0000);

    // Reset while a colliding read is pending: the read must not be served afterwards.
    do_reset();
    @(negedge clk);
    wr_done = 1'b1; rd_req = 1'b1;
    @(negedge clk);
    rst = 1'b1; wr_done = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_reset(0); m_reset(1);
    repeat (3) @(negedge clk);
    chk_acks("pend_clear", 4'b0000);
    check_all("pend_clear");

    // Random traffic.
    do_reset();
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 2))
        0: do_write();
        1: do_read();
        default: do_both();
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
